// File: rtl/check_parity_pitch_pkg.sv
// ============================================================================
// Module      : check_parity_pitch_pkg
// Description : Shared encodings and constants for the pitch-parity blocks.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package check_parity_pitch_pkg;

  localparam int c_DATA_W = 16;
  localparam int c_NBITS  = 6;
  localparam logic [c_DATA_W-1:0] c_ONE = 16'd1;

  typedef enum logic [3:0] {
    ST_INIT = 4'd0,
    ST_S1   = 4'd1,
    ST_S2   = 4'd2,
    ST_S3   = 4'd3,
    ST_S4   = 4'd4,
    ST_S5   = 4'd5,
    ST_S6   = 4'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/check_parity_pitch.sv
// ============================================================================
// Module      : check_parity_pitch
// Description : Decoder-side parity check of the first-subframe pitch index.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module check_parity_pitch
  import check_parity_pitch_pkg::*;
#(
  parameter int WIDTH = c_DATA_W,
  parameter int NBITS = c_NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pitch_index,
  input  logic [WIDTH-1:0] parity,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_in,
  output logic [WIDTH-1:0] shr_a,
  output logic [WIDTH-1:0] shr_b,
  input  logic [WIDTH-1:0] shr_in
);

  localparam logic [WIDTH-1:0] c_UNIT  = WIDTH'(c_ONE);
  localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(NBITS);

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_i, w_i;
  logic [WIDTH-1:0] r_temp, w_temp;
  logic [WIDTH-1:0] r_bit1, w_bit1;
  logic [WIDTH-1:0] r_index, w_index;
  logic [WIDTH-1:0] r_parity, w_parity;
  logic [WIDTH-1:0] r_sum, w_sum;
  logic             r_done, w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_INIT;
      r_i      <= '0;
      r_temp   <= '0;
      r_bit1   <= '0;
      r_index  <= '0;
      r_parity <= '0;
      r_sum    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_i      <= w_i;
      r_temp   <= w_temp;
      r_bit1   <= w_bit1;
      r_index  <= w_index;
      r_parity <= w_parity;
      r_sum    <= w_sum;
      r_done   <= w_done;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_i      = r_i;
    w_temp   = r_temp;
    w_bit1   = r_bit1;
    w_index  = r_index;
    w_parity = r_parity;
    w_sum    = r_sum;
    w_done   = r_done;
    add_a    = '0;
    add_b    = '0;
    shr_a    = '0;
    shr_b    = '0;

    unique case (r_state)
      ST_INIT: begin
        if (start) begin
          w_index  = pitch_index;
          w_parity = parity;
          w_state  = ST_S1;
        end
      end
      ST_S1: begin
        shr_a   = r_index;
        shr_b   = c_UNIT;
        w_temp  = shr_in;
        w_sum   = c_UNIT;
        w_i     = '0;
        w_state = ST_S2;
      end
      ST_S2: begin
        if (r_i == c_LIMIT) begin
          w_state = ST_S4;
        end else begin
          // The extracted bit feeds the adder in the same cycle it is captured.
          shr_a   = r_temp;
          shr_b   = c_UNIT;
          w_temp  = shr_in;
          w_bit1  = shr_in & c_UNIT;
          add_a   = r_sum;
          add_b   = shr_in & c_UNIT;
          w_sum   = add_in;
          w_state = ST_S3;
        end
      end
      ST_S3: begin
        add_a   = r_i;
        add_b   = c_UNIT;
        w_i     = add_in;
        w_state = ST_S2;
      end
      ST_S4: begin
        add_a   = r_sum;
        add_b   = r_parity;
        w_sum   = add_in;
        w_state = ST_S5;
      end
      ST_S5: begin
        w_sum   = r_sum & c_UNIT;
        w_done  = 1'b1;
        w_state = ST_S6;
      end
      ST_S6: begin
        w_done  = 1'b0;
        w_state = ST_INIT;
      end
      default: w_state = ST_INIT;
    endcase
  end

  assign done = r_done;
  assign sum  = r_sum | (r_bit1 & '0);

endmodule

`default_nettype wire
